// File: rtl/preamble_tx.sv
// 802.11a/g legacy preamble source: NUM_STS_REPS short periods, GI2, then two long
// training symbols, streamed as Q1.15 I/Q on an AXI-Stream master at one sample per clock.
module preamble_tx #(
   parameter int NUM_STS_REPS = 10,
   parameter bit TLAST_EN     = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        start_in,
   output logic        busy_out,
   output logic        tx_axis_tvalid,
   input  logic        tx_axis_tready,
   output logic [15:0] tx_i_axis_tdata,
   output logic [15:0] tx_q_axis_tdata,
   output logic [1:0]  tx_axis_tuser,
   output logic        tx_axis_tlast
);

   typedef enum logic [2:0] {S_IDLE, S_STS, S_GI2, S_LTS1, S_LTS2} state_t;

   typedef struct packed {
      logic [15:0] i;
      logic [15:0] q;
      logic [1:0]  tag;
      logic        last;
   } sample_t;

   localparam logic [3:0] LAST_REP = 4'(NUM_STS_REPS - 1);

   state_t      state, nxt_state;
   logic [3:0]  sts_idx, nxt_sts_idx;
   logic [3:0]  sts_rep, nxt_sts_rep;
   logic [5:0]  lts_idx, nxt_lts_idx;
   logic [31:0] sts_iq, lts_iq;
   sample_t     nxt;
   logic        load;

   function automatic logic [31:0] iq(input int re, input int im);
      return {16'(re), 16'(im)};
   endfunction

   // Time-domain training symbols, round(v*32768).
   function automatic logic [31:0] sts_rom(input logic [3:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         4'd0:  r = iq( 1507,  1507);
         4'd1:  r = iq(-4325,    66);
         4'd2:  r = iq( -426, -2589);
         4'd3:  r = iq( 4686,  -426);
         4'd4:  r = iq( 3015,     0);
         4'd5:  r = iq( 4686,  -426);
         4'd6:  r = iq( -426, -2589);
         4'd7:  r = iq(-4325,    66);
         4'd8:  r = iq( 1507,  1507);
         4'd9:  r = iq(   66, -4325);
         4'd10: r = iq(-2589,  -426);
         4'd11: r = iq( -426,  4686);
         4'd12: r = iq(    0,  3015);
         4'd13: r = iq( -426,  4686);
         4'd14: r = iq(-2589,  -426);
         4'd15: r = iq(   66, -4325);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lts_rom(input logic [5:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         6'd0:  r = iq( 5112,     0);
         6'd1:  r = iq( -164, -3932);
         6'd2:  r = iq( 1311, -3637);
         6'd3:  r = iq( 3178,  2720);
         6'd4:  r = iq(  688,   918);
         6'd5:  r = iq( 1966, -2884);
         6'd6:  r = iq(-3768, -1802);
         6'd7:  r = iq(-1245, -3473);
         6'd8:  r = iq( 3211,  -852);
         6'd9:  r = iq( 1737,   131);
         6'd10: r = iq(   33, -3768);
         6'd11: r = iq(-4489, -1540);
         6'd12: r = iq(  786, -1933);
         6'd13: r = iq( 1933,  -492);
         6'd14: r = iq( -721,  5276);
         6'd15: r = iq( 3899,  -131);
         6'd16: r = iq( 2032,  2032);
         6'd17: r = iq( 1212, -3211);
         6'd18: r = iq(-1868, -1278);
         6'd19: r = iq(-4293, -2130);
         6'd20: r = iq( 2687, -3015);
         6'd21: r = iq( 2294,  -459);
         6'd22: r = iq(-1966, -2654);
         6'd23: r = iq(-1835,   721);
         6'd24: r = iq(-1147,  4948);
         6'd25: r = iq(-3998,   557);
         6'd26: r = iq(-4162,   688);
         6'd27: r = iq( 2458,  2425);
         6'd28: r = iq(  -98, -1769);
         6'd29: r = iq(-3015,  3768);
         6'd30: r = iq( 3015,  3473);
         6'd31: r = iq(  393,  3211);
         6'd32: r = iq(-5112,     0);
         6'd33: r = iq(  393, -3211);
         6'd34: r = iq( 3015, -3473);
         6'd35: r = iq(-3015, -3768);
         6'd36: r = iq(  -98,  1769);
         6'd37: r = iq( 2458, -2425);
         6'd38: r = iq(-4162,  -688);
         6'd39: r = iq(-3998,  -557);
         6'd40: r = iq(-1147, -4948);
         6'd41: r = iq(-1835,  -721);
         6'd42: r = iq(-1966,  2654);
         6'd43: r = iq( 2294,   459);
         6'd44: r = iq( 2687,  3015);
         6'd45: r = iq(-4293,  2130);
         6'd46: r = iq(-1868,  1278);
         6'd47: r = iq( 1212,  3211);
         6'd48: r = iq( 2032, -2032);
         6'd49: r = iq( 3899,   131);
         6'd50: r = iq( -721, -5276);
         6'd51: r = iq( 1933,   492);
         6'd52: r = iq(  786,  1933);
         6'd53: r = iq(-4489,  1540);
         6'd54: r = iq(   33,  3768);
         6'd55: r = iq( 1737,  -131);
         6'd56: r = iq( 3211,   852);
         6'd57: r = iq(-1245,  3473);
         6'd58: r = iq(-3768,  1802);
         6'd59: r = iq( 1966,  2884);
         6'd60: r = iq(  688,  -918);
         6'd61: r = iq( 3178, -2720);
         6'd62: r = iq( 1311,  3637);
         6'd63: r = iq( -164,  3932);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Counters always point at the sample currently on the bus; this computes the one after it.
   always_comb begin
      nxt_state   = state;
      nxt_sts_idx = sts_idx;
      nxt_sts_rep = sts_rep;
      nxt_lts_idx = lts_idx;
      case (state)
         S_IDLE: begin
            nxt_state   = S_STS;
            nxt_sts_idx = '0;
            nxt_sts_rep = '0;
            nxt_lts_idx = '0;
         end
         S_STS: begin
            nxt_sts_idx = sts_idx + 4'd1;
            if (sts_idx == 4'd15) begin
               if (sts_rep == LAST_REP) begin
                  nxt_state   = S_GI2;
                  nxt_sts_rep = '0;
                  nxt_lts_idx = 6'd32;
               end else begin
                  nxt_sts_rep = sts_rep + 4'd1;
               end
            end
         end
         S_GI2: begin
            nxt_lts_idx = lts_idx + 6'd1;
            if (lts_idx == 6'd63) nxt_state = S_LTS1;
         end
         S_LTS1: begin
            nxt_lts_idx = lts_idx + 6'd1;
            if (lts_idx == 6'd63) nxt_state = S_LTS2;
         end
         S_LTS2: begin
            nxt_lts_idx = lts_idx + 6'd1;
            if (lts_idx == 6'd63) nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      sts_iq = sts_rom(nxt_sts_idx);
      lts_iq = lts_rom(nxt_lts_idx);
      nxt    = '0;
      if (nxt_state == S_STS)       {nxt.i, nxt.q} = sts_iq;
      else if (nxt_state != S_IDLE) {nxt.i, nxt.q} = lts_iq;
      case (nxt_state)
         S_GI2:   nxt.tag = 2'd1;
         S_LTS1:  nxt.tag = 2'd2;
         S_LTS2:  nxt.tag = 2'd3;
         default: nxt.tag = 2'd0;
      endcase
      nxt.last = TLAST_EN && (nxt_state == S_LTS2) && (nxt_lts_idx == 6'd63);
   end

   // Outside IDLE tvalid is always high, so a load is exactly an accepted beat.
   assign load = (state == S_IDLE) ? start_in : (tx_axis_tvalid & tx_axis_tready);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state           <= S_IDLE;
         sts_idx         <= '0;
         sts_rep         <= '0;
         lts_idx         <= '0;
         busy_out        <= 1'b0;
         tx_axis_tvalid  <= 1'b0;
         tx_i_axis_tdata <= '0;
         tx_q_axis_tdata <= '0;
         tx_axis_tuser   <= '0;
         tx_axis_tlast   <= 1'b0;
      end else if (load) begin
         state           <= nxt_state;
         sts_idx         <= nxt_sts_idx;
         sts_rep         <= nxt_sts_rep;
         lts_idx         <= nxt_lts_idx;
         busy_out        <= (nxt_state != S_IDLE);
         tx_axis_tvalid  <= (nxt_state != S_IDLE);
         tx_i_axis_tdata <= nxt.i;
         tx_q_axis_tdata <= nxt.q;
         tx_axis_tuser   <= nxt.tag;
         tx_axis_tlast   <= nxt.last;
      end
   end

endmodule

// File: doc/preamble_tx.md
Name: preamble_tx

Overview:
- Transmit-side counterpart of the receive LTS alignment path.
- On a start pulse, streams one 802.11a/g legacy preamble as 20 MSPS signed I/Q samples on an AXI-Stream master: short training sequence (STS), LTS guard interval (GI2), then two long training symbols (LTS1, LTS2).
- Sits at the head of the TX chain, ahead of the DATA-symbol IFFT/CP path, and drives DAC/loopback benches for the receiver.

Parameters:
- NUM_STS_REPS, 10, number of 16-sample STS periods emitted; legal range 1..15.
- TLAST_EN, 1, 1 = assert tlast on the final preamble sample; 0 = tlast held 0 so a following DATA stream continues the packet.

Ports:
- clk_in  input  1  system clock, 20 MSPS sample rate domain
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  single-cycle request to emit one preamble; honoured only in IDLE
- busy_out  output  1  high from start acceptance until the final sample handshake
- tx_axis_tvalid  output  1  sample valid
- tx_axis_tready  input  1  downstream ready
- tx_i_axis_tdata  output  16  signed I, Q1.15
- tx_q_axis_tdata  output  16  signed Q, Q1.15
- tx_axis_tuser  output  2  segment tag: 0 STS, 1 GI2, 2 LTS1, 3 LTS2
- tx_axis_tlast  output  1  end of preamble, only when TLAST_EN=1

Behaviour:
- Clock and reset: one clock (clk_in). Reset is asynchronous and active-low (rst_n_in).
- Reset values: all outputs 0. State is IDLE. All counters are 0. Reset assertion mid-packet drops tvalid immediately (asynchronously) with no tlast. After release the block idles until a new start_in.
- Tables: constant ROMs hold the IEEE 802.11 time-domain samples, each value round(v*32768), saturated to 16 bits.
  - STS[0..15], e.g. STS[0] = 0.046+0.046j gives (1507, 1507).
  - LTS[0..63], e.g. LTS[0] = 0.156+0j gives (5112, 0); LTS[32] = -0.156+0j gives (-5112, 0).
  - No boundary windowing.
- Sample order, total N = 16*NUM_STS_REPS + 160:
  - STS: STS[k mod 16] for k = 0..16*NUM_STS_REPS-1, tuser 0.
  - GI2: LTS[32..63], tuser 1.
  - LTS1: LTS[0..63], tuser 2.
  - LTS2: LTS[0..63], tuser 3.
- FSM states: IDLE, STS, GI2, LTS1, LTS2.
  - IDLE -> STS on start_in=1. On the next clock: tvalid=1 presenting STS[0], busy_out=1. Latency is 1 cycle.
  - Segment transitions occur on the handshake (tvalid & tready) of each segment's last sample.
  - LTS2 -> IDLE on the handshake of LTS[63]. In the same clock tvalid falls and busy_out falls.
- Counters:
  - 4-bit STS period index and 4-bit repetition counter; terminal when rep = NUM_STS_REPS-1 and index = 15.
  - 6-bit LTS index, loaded to 32 at GI2 entry. It wraps 63 -> 0 naturally when entering LTS1 and LTS2.
- Handshake (AXI-Stream master rules):
  - Output registers are loaded from the ROM pipeline so tdata/tuser/tlast are registered.
  - While tvalid=1 and tready=0, tdata, tuser and tlast hold stable and counters do not advance.
  - tvalid never drops mid-preamble.
  - Zero-bubble throughput: one sample per clock while tready=1.
- tlast: asserted only with the final LTS2 sample (LTS[63]) when TLAST_EN=1.
- start_in while busy: ignored, not queued, including a start in the same cycle as the final handshake. A start one cycle later is accepted.
- Back-pressure at a segment boundary: the boundary sample holds, and tuser changes only after it is accepted.

Test Plan:
- Reset then single start_in pulse, tready=1: tvalid rises 1 cycle later; exactly 320 beats; beat0 = (1507, 1507) tuser 0; beat160 = LTS[32] = (-5112, 0) tuser 1; beat192 = (5112, 0) tuser 2; beat256 = (5112, 0) tuser 3; tlast only on beat 319; busy_out falls with it.
- Random tready (50% duty): captured stream is bit-identical to the tready=1 capture; tdata and tuser stable on every stalled cycle; tvalid never drops before the last beat.
- start_in pulsed at beats 5, 319 (same cycle as final handshake) and 319+1: the first and third pulses each yield one full preamble; the second is ignored; total 640 beats.
- NUM_STS_REPS=2, TLAST_EN=0: 192 beats with tuser 0 for beats 0..31; tlast never asserted.
- rst_n_in pulsed low at beat 100 with tready=1: tvalid, busy_out and tlast go 0 asynchronously; no further beats until a new start, which produces a clean 320-beat preamble from STS[0].
- Loopback: preamble (after 64 zero samples) drives the receive LTS alignment block; it detects two correlation peaks 64 apart and outputs 128 LTS samples matching LTS[0..63] twice.
